// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Width of the status counters that exist when statistics are compiled in.
    localparam int CNT_W = 16;

    // FIFO pointers carry one extra wrap bit above the address bits.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with wrap-bit pointers and a combinational head.
// Latency: a push is visible at the head one cycle later; pop takes effect on the same edge.
// Backpressure: push while full is ignored unless a pop frees the slot on the same edge.
module uart_sync_fifo
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic [DATA_W-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    // A pop on an empty FIFO is meaningless; a pop frees room for a push on a full one.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; flush discards all contents at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences a UART receiver: buffers completed bytes, recovers from errors (idle wait, reset pulse).
// Latency: done edge to m_valid is one cycle; error to DRAIN is one cycle. Optional stats: UART_RX_CTRL_STATS_EN.
// Backpressure: m_ready stalls the head; a byte arriving while full is dropped and flagged in overflow.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int IDLE_TICKS = 160,
    parameter int RST_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_en,
    input  logic                          tick,
    input  logic                          rx_line,
    input  logic                          rxu_done,
    input  logic [DATA_W-1:0]             rxu_dout,
    input  logic                          rxu_error,
    output logic                          rxu_rst_n,
    output logic                          m_valid,
    output logic [DATA_W-1:0]             m_data,
    input  logic                          m_ready,
    output logic                          overflow,
    input  logic                          clr_status,
    output logic [1:0]                    state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_RX_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [CNT_W-1:0]              drop_cnt
`endif
);
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic              line_s1;
    logic              line_s2;
    logic              done_q;
    logic              rst_q;
    logic              overflow_q;
    logic [IDLE_W-1:0] idle_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              idle_done;
    logic              push;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    // Bytes are only taken while running; an enable drop in the same cycle wins.
    assign push      = rxu_done && !done_q && (state_q == ST_ACTIVE) && rx_en;
    assign pop       = m_valid && m_ready;
    assign drop      = push && full && !pop;
    assign idle_done = (state_q == ST_DRAIN) && tick && line_s2 && (idle_cnt == IDLE_LAST);

    assign m_valid   = !empty;
    assign m_data    = empty ? '0 : head;
    assign rxu_rst_n = rst_q;
    assign overflow  = overflow_q;
    assign state     = state_q;

    // Next-state selection; losing the enable overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:    state_d = ST_ACTIVE;
                ST_ACTIVE: if (rxu_error) state_d = ST_DRAIN;
                ST_DRAIN:  if (idle_done) state_d = ST_HOLD;
                ST_HOLD:   if (hold_cnt == HOLD_LAST) state_d = ST_ACTIVE;
                default:   state_d = ST_OFF;
            endcase
        end
    end

    // State register plus receiver reset, registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rst_q   <= (state_d == ST_ACTIVE) || (state_d == ST_DRAIN);
        end
    end

    // Line synchronizer (idles high) and done-level edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_s1 <= 1'b1;
            line_s2 <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            line_s1 <= rx_line;
            line_s2 <= line_s1;
            done_q  <= rxu_done;
        end
    end

    // Idle qualification in DRAIN and reset-pulse length in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            if (state_q != ST_DRAIN || !line_s2 || idle_done) idle_cnt <= '0;
            else if (tick)                                    idle_cnt <= idle_cnt + 1'b1;

            if (state_q == ST_HOLD && state_d == ST_HOLD) hold_cnt <= hold_cnt + 1'b1;
            else                                          hold_cnt <= '0;
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          overflow_q <= 1'b0;
        else if (drop)       overflow_q <= 1'b1;
        else if (clr_status) overflow_q <= 1'b0;
    end

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (!rx_en),
        .push      (push),
        .push_data (rxu_dout),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count),
        .head      (head)
    );

`ifdef UART_RX_CTRL_STATS_EN
    logic err_evt;
    assign err_evt = (state_q == ST_ACTIVE) && (state_d == ST_DRAIN);

    // Saturating event counters; an event coinciding with a clear counts as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else if (clr_status) begin
            err_cnt  <= err_evt ? CNT_W'(1) : '0;
            drop_cnt <= drop    ? CNT_W'(1) : '0;
        end else begin
            if (err_evt && err_cnt  != '1) err_cnt  <= err_cnt  + CNT_W'(1);
            if (drop    && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames, overflow, error recovery, enable drop, async reset.
// Latency: expected bytes queued at stimulus time, compared when the DUT hands a byte over.
// Backpressure: the bench toggles m_ready to fill, stall and drain the FIFO.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_en = 1'b0;
    logic       tick = 1'b0;
    logic       rx_line = 1'b1;
    logic       rxu_done = 1'b0;
    logic [7:0] rxu_dout = 8'h00;
    logic       rxu_error = 1'b0;
    logic       rxu_rst_n;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       overflow;
    logic       clr_status = 1'b0;
    logic [1:0] state;
    logic [3:0] fifo_count;
`ifdef UART_RX_CTRL_STATS_EN
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_en      (rx_en),
        .tick       (tick),
        .rx_line    (rx_line),
        .rxu_done   (rxu_done),
        .rxu_dout   (rxu_dout),
        .rxu_error  (rxu_error),
        .rxu_rst_n  (rxu_rst_n),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .overflow   (overflow),
        .clr_status (clr_status),
        .state      (state),
        .fifo_count (fifo_count)
`ifdef UART_RX_CTRL_STATS_EN
        ,
        .err_cnt    (err_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Baud strobe every 4 clocks, changed 2 time units after the edge.
    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            #2;
            tick = (div == 3);
            div  = (div + 1) % 4;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted head byte must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra: got %0h expected none", m_data);
                end else begin
                    chk("sb_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // One receiver frame: done held 16 clocks; optional pop/clear on the rising-edge cycle.
    task automatic send_frame(input logic [7:0] b, input bit pop_edge, input bit clr_edge);
        rxu_dout = b;
        rxu_done = 1'b1;
        if (pop_edge) m_ready = 1'b1;
        if (clr_edge) clr_status = 1'b1;
        cyc(1);
        if (pop_edge) m_ready = 1'b0;
        clr_status = 1'b0;
        cyc(15);
        rxu_done = 1'b0;
        cyc(3);
    endtask

    task automatic drain(input string nm);
        m_ready = 1'b1;
        for (int i = 0; i < 200 && fifo_count != 0; i++) cyc(1);
        cyc(1);
        m_ready = 1'b0;
        chk(nm, {28'h0, fifo_count}, 32'h0);
        chk({nm, "_sb_empty"}, exp_q.size(), 32'h0);
    endtask

    task automatic wait_hold(input string nm, output int ticks);
        ticks = 0;
        for (int i = 0; i < 1500 && state != 2'd3; i++) begin
            cyc(1);
            if (tick) ticks++;
        end
        chk(nm, {30'h0, state}, 32'd3);
    endtask

    initial begin
        int ticks;
        int hold_cycles;

        // Reset state
        cyc(3);
        chk("rst_state", {30'h0, state}, 32'd0);
        chk("rst_rxu_rst_n", {31'h0, rxu_rst_n}, 32'd0);
        chk("rst_m_valid", {31'h0, m_valid}, 32'd0);
        chk("rst_m_data", {24'h0, m_data}, 32'd0);
        chk("rst_overflow", {31'h0, overflow}, 32'd0);
        chk("rst_count", {28'h0, fifo_count}, 32'd0);
        rst_n = 1'b1;
        cyc(2);
        chk("off_hold", {30'h0, state}, 32'd0);
        rx_en = 1'b1;
        cyc(1);
        chk("en_state", {30'h0, state}, 32'd1);
        chk("en_rxu_rst_n", {31'h0, rxu_rst_n}, 32'd1);

        // Three frames streamed straight through
        m_ready = 1'b1;
        exp_q.push_back(8'h55); send_frame(8'h55, 1'b0, 1'b0);
        exp_q.push_back(8'hA3); send_frame(8'hA3, 1'b0, 1'b0);
        exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b0, 1'b0);
        cyc(2);
        m_ready = 1'b0;
        chk("stream_sb_empty", exp_q.size(), 32'd0);
        chk("stream_overflow", {31'h0, overflow}, 32'd0);

        // Overflow: nine frames into eight slots, clear coinciding with the drop
        rxu_dout = 8'h01;
        rxu_done = 1'b1;
        exp_q.push_back(8'h01);
        cyc(1);
        chk("lat_m_valid", {31'h0, m_valid}, 32'd1);
        chk("lat_m_data", {24'h0, m_data}, 32'h01);
        cyc(15);
        rxu_done = 1'b0;
        cyc(3);
        for (int i = 2; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b0, 1'b0);
        end
        send_frame(8'h09, 1'b0, 1'b1);
        chk("ovf_count", {28'h0, fifo_count}, 32'd8);
        chk("ovf_flag", {31'h0, overflow}, 32'd1);
        chk("ovf_head_stable", {24'h0, m_data}, 32'h01);
`ifdef UART_RX_CTRL_STATS_EN
        chk("ovf_drop_cnt", {16'h0, drop_cnt}, 32'd1);
`endif
        drain("ovf_drain");
        clr_status = 1'b1;
        cyc(1);
        clr_status = 1'b0;
        chk("clr_overflow", {31'h0, overflow}, 32'd0);
`ifdef UART_RX_CTRL_STATS_EN
        chk("clr_drop_cnt", {16'h0, drop_cnt}, 32'd0);
`endif

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
        end
        chk("full_count", {28'h0, fifo_count}, 32'd8);
        exp_q.push_back(8'h18);
        send_frame(8'h18, 1'b1, 1'b0);
        chk("pushpop_count", {28'h0, fifo_count}, 32'd8);
        chk("pushpop_overflow", {31'h0, overflow}, 32'd0);
        drain("pushpop_drain");

        // Error recovery with FIFO contents preserved across HOLD
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            send_frame(8'h20 + 8'(i), 1'b0, 1'b0);
        end
        rxu_error = 1'b1;
        cyc(1);
        chk("err_drain", {30'h0, state}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            ticks = 0;
            for (int i = 0; i < 1000 && ticks < 100; i++) begin
                cyc(1);
                if (tick) ticks++;
            end
            rx_line = 1'b0;
            cyc(8);
            rx_line = 1'b1;
        end
        chk("toggle_stays_drain", {30'h0, state}, 32'd2);
        wait_hold("idle_to_hold", ticks);
        chk("idle_ticks_ok", {31'h0, (ticks >= 160 && ticks <= 161)}, 32'd1);
        hold_cycles = 0;
        for (int i = 0; i < 20 && state == 2'd3; i++) begin
            if (!rxu_rst_n) begin
                hold_cycles++;
                rxu_error = 1'b0;
            end
            chk("hold_count_kept", {28'h0, fifo_count}, 32'd3);
            cyc(1);
        end
        chk("hold_len", hold_cycles, 32'd4);
        chk("hold_exit_state", {30'h0, state}, 32'd1);
        chk("hold_exit_rst_n", {31'h0, rxu_rst_n}, 32'd1);
        chk("after_hold_count", {28'h0, fifo_count}, 32'd3);
`ifdef UART_RX_CTRL_STATS_EN
        chk("err_cnt_1", {16'h0, err_cnt}, 32'd1);
`endif
        drain("recov_drain");

        // Enable dropped in HOLD with three bytes buffered (they are flushed)
        for (int i = 1; i <= 3; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b0);
        chk("pre_off_count", {28'h0, fifo_count}, 32'd3);
        rxu_error = 1'b1;
        cyc(1);
        wait_hold("hold_again", ticks);
        rx_en = 1'b0;
        cyc(1);
        rxu_error = 1'b0;
        chk("off_state", {30'h0, state}, 32'd0);
        chk("off_count", {28'h0, fifo_count}, 32'd0);
        chk("off_m_valid", {31'h0, m_valid}, 32'd0);
        chk("off_rxu_rst_n", {31'h0, rxu_rst_n}, 32'd0);
`ifdef UART_RX_CTRL_STATS_EN
        chk("err_cnt_2", {16'h0, err_cnt}, 32'd2);
`endif

        // Asynchronous reset in the middle of DRAIN
        rx_en = 1'b1;
        cyc(1);
        send_frame(8'h41, 1'b0, 1'b0);
        rxu_error = 1'b1;
        cyc(2);
        chk("pre_rst_drain", {30'h0, state}, 32'd2);
        chk("pre_rst_count", {28'h0, fifo_count}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_state", {30'h0, state}, 32'd0);
        chk("arst_rxu_rst_n", {31'h0, rxu_rst_n}, 32'd0);
        chk("arst_m_valid", {31'h0, m_valid}, 32'd0);
        chk("arst_m_data", {24'h0, m_data}, 32'd0);
        chk("arst_count", {28'h0, fifo_count}, 32'd0);
        chk("arst_overflow", {31'h0, overflow}, 32'd0);
        rx_en = 1'b0;
        rxu_error = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst_state", {30'h0, state}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
